// File: rtl/store_narrow_unit.sv
// Store narrowing unit: turns SB/SH/SW pipeline stores into word-aligned,
// lane-replicated memory writes with byte enables, alignment checks and an ack timeout.
module store_narrow_unit #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REQ,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  code_q, code_d;

   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic        misaligned;

   // Little-endian lane placement of the captured store.
   always_comb begin
      lane_wdata = data_q;
      lane_be    = 4'b1111;
      misaligned = 1'b0;
      unique case (size_q)
         2'b00: begin
            lane_wdata = {4{data_q[7:0]}};
            lane_be    = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            lane_wdata = {2{data_q[15:0]}};
            lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            misaligned = addr_q[0];
         end
         2'b10: begin
            misaligned = (addr_q[1:0] != 2'b00);
         end
         default: begin
            lane_wdata = data_q;
            lane_be    = 4'b0000;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      code_d  = code_q;
      unique case (state_q)
         S_IDLE: begin
            if (st_valid) begin
               size_d  = st_size;
               addr_d  = st_addr;
               data_d  = st_data;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (size_q == 2'b11) begin
               code_d  = 2'b10;
               state_d = S_ERR;
            end else if (misaligned) begin
               code_d  = 2'b01;
               state_d = S_ERR;
            end else begin
               maddr_d = {addr_q[31:2], 2'b00};
               wdata_d = lane_wdata;
               be_d    = lane_be;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // An ack on the final allowed cycle still completes the store.
            if (mem_ack) begin
               state_d = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               code_d  = 2'b11;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         size_q  <= 2'b00;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         maddr_q <= '0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         code_q  <= code_d;
      end
   end

   assign st_ready  = (state_q == S_IDLE);
   assign mem_req   = (state_q == S_REQ);
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = (state_q == S_REQ) ? be_q : 4'b0000;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign err_code  = (state_q == S_ERR) ? code_q : 2'b00;

endmodule
